mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
//  Accepts the 71-bit execute-to-memory bus and receives the synchronous data-SRAM read data, one cycle
//  after the execute stage drove the address. Selects ALU result vs load data and forwards the result to
//  writeback. Drives dest/value bypass to decode.
//  Holds load data stable across writeback back-pressure.
// PARAMETERS
//  XLEN      32  datapath / SRAM data width
//  ES_BUS_W  71  width of es_to_ms_bus ({res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]})
//  MS_BUS_W  70  width of ms_to_ws_bus ({gr_we, dest[4:0], final_result[31:0], pc[31:0]})
// PORTS
//  clk               in   1         clock, all state on rising edge
//  reset             in   1         asynchronous, active-high reset
//  ws_allowin        in   1         writeback can accept this cycle
//  ms_allowin        out  1         this stage can accept from execute
//  es_to_ms_valid    in   1         execute presents a valid instruction
//  es_to_ms_bus      in   ES_BUS_W  [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] result, [31:0] pc
//  ms_to_ws_valid    out  1         valid instruction offered to writeback
//  ms_to_ws_bus      out  MS_BUS_W  [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc
//  data_sram_rdata   in   XLEN      SRAM read data, valid the cycle after the address was presented
//  ms_to_ds_dest     out  5         bypass dest; 0 when no valid register write
//  ms_to_ds_value    out  XLEN      bypass value; 0 when no valid register write
// BEHAVIOUR
//  - Reset: ms_valid=0, bus register=0, rdata_hold=0, first_cyc=0, all outputs 0 except ms_allowin=1.
//    Reset is asynchronous and acts at any time, including mid-stall: the in-flight instruction is
//    dropped and no write is offered to writeback.
//  - ms_ready_go=1 (fixed). ms_allowin = !ms_valid | ws_allowin. ms_to_ws_valid = ms_valid.
//  - Accept: es_to_ms_valid & ms_allowin -> the bus register loads es_to_ms_bus, ms_valid<=1, first_cyc<=1.
//    ms_allowin & !es_to_ms_valid -> ms_valid<=0. Otherwise the register and ms_valid hold.
//  - Load data capture (two states, tracked by first_cyc):
//    FIRST:
//      - The cycle immediately after accept.
//      - load_data = data_sram_rdata, and rdata_hold<=data_sram_rdata.
//      - If the stage is not accepting a new instruction this cycle, first_cyc<=0.
//    HELD:
//      - Any later stall cycle.
//      - load_data = rdata_hold.
//      - The SRAM output may have been overwritten by execute's next access, so data_sram_rdata is
//        ignored here.
//    - A new accept always returns to FIRST, including back-to-back accepts without a stall.
//  - final_result = res_from_mem ? load_data : result. Word loads only; no byte/half extraction.
//  - Bypass: ms_to_ds_dest = (ms_valid & gr_we) ? dest : 0; ms_to_ds_value = same mask on final_result.
//    The bypass output is combinational and is valid in FIRST as well as HELD.
//  - Latency: 1 cycle execute->writeback when ws_allowin=1. The stage never drops or duplicates an
//    instruction.
//  - Simultaneous accept and departure: when ws_allowin=1, the old instruction leaves and the new one
//    enters in the same edge (ms_valid stays 1).
// TESTING
//  1 ALU op: bus {0,1,5'd3,32'h0000_1234,32'h1c00_0000}, ws_allowin=1 -> next cycle ms_to_ws_bus final_result
//    =0x1234, dest=3; ms_to_ds_dest=3, ms_to_ds_value=0x1234.
//  2 Load, no stall: res_from_mem=1, dest=4, rdata=0xDEAD_BEEF in first cycle -> final_result=0xDEADBEEF,
//    ms_to_ws_valid=1 for exactly 1 cycle.
//  3 Load under stall: ws_allowin=0 for 3 cycles, rdata 0xDEADBEEF then 0x1111_1111 -> final_result stays
//    0xDEADBEEF all 4 cycles; ms_allowin=0 during the stall.
//  4 Back-to-back loads 0xA5A5_0001, 0xA5A5_0002 with ws_allowin=1 -> two consecutive outputs with the
//    matching values, no bubble.
//  5 gr_we=0 store passing through -> ms_to_ds_dest=0, ms_to_ds_value=0, while ms_to_ws_valid=1.
//  6 Assert reset mid-stall (async, between edges) -> ms_to_ws_valid=0 and ms_allowin=1 immediately; after
//    release, next accept behaves as scenario 2.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute->memory->writeback handshake, SRAM read data and decode bypass for the memory stage.
// "slave" is the stage itself; "master" is the surrounding pipeline or testbench.
interface mem_stage_if #(
  parameter int XLEN     = 32,
  parameter int ES_BUS_W = 71,
  parameter int MS_BUS_W = 70
);
  logic                ws_allowin;
  logic                ms_allowin;
  logic                es_to_ms_valid;
  logic [ES_BUS_W-1:0] es_to_ms_bus;
  logic                ms_to_ws_valid;
  logic [MS_BUS_W-1:0] ms_to_ws_bus;
  logic [XLEN-1:0]     data_sram_rdata;
  logic [4:0]          ms_to_ds_dest;
  logic [XLEN-1:0]     ms_to_ds_value;

  modport master (
    output ws_allowin,
    output es_to_ms_valid,
    output es_to_ms_bus,
    output data_sram_rdata,
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_to_ds_dest,
    input  ms_to_ds_value
  );

  modport slave (
    input  ws_allowin,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  data_sram_rdata,
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_to_ds_dest,
    output ms_to_ds_value
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: picks ALU result or SRAM load data, 1-cycle latency, and
// stalls on !ws_allowin while holding the load word that was captured in the first cycle.
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int ES_BUS_W = 71,
  parameter int MS_BUS_W = 70
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms_if
);

  typedef struct packed {
    logic            res_from_mem;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] final_result;
    logic [XLEN-1:0] pc;
  } ms_bus_t;

  // FIRST: SRAM output belongs to this instruction; HELD: SRAM output may be stale.
  typedef enum logic {
    LD_HELD  = 1'b0,
    LD_FIRST = 1'b1
  } ld_state_e;

  es_bus_t   es_bus;
  ms_bus_t   ms_bus;

  logic      ms_valid_q,   ms_valid_d;
  es_bus_t   bus_q,        bus_d;
  logic [XLEN-1:0] rdata_hold_q, rdata_hold_d;
  ld_state_e ld_state_q,   ld_state_d;

  logic            ms_allowin;
  logic            accept;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] final_result;
  logic            bypass_en;

  assign es_bus     = es_bus_t'(ms_if.es_to_ms_bus);
  assign ms_allowin = !ms_valid_q || ms_if.ws_allowin;
  assign accept     = ms_if.es_to_ms_valid && ms_allowin;

  always_comb begin
    ms_valid_d   = ms_valid_q;
    bus_d        = bus_q;
    rdata_hold_d = rdata_hold_q;
    ld_state_d   = ld_state_q;

    if (ms_allowin) begin
      ms_valid_d = ms_if.es_to_ms_valid;
    end

    if (ld_state_q == LD_FIRST) begin
      rdata_hold_d = ms_if.data_sram_rdata;
      ld_state_d   = LD_HELD;
    end

    // A new accept re-arms FIRST even when the previous instruction is still in FIRST.
    if (accept) begin
      bus_d      = es_bus;
      ld_state_d = LD_FIRST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      rdata_hold_q <= '0;
      ld_state_q   <= LD_HELD;
    end else begin
      ms_valid_q   <= ms_valid_d;
      bus_q        <= bus_d;
      rdata_hold_q <= rdata_hold_d;
      ld_state_q   <= ld_state_d;
    end
  end

  always_comb begin
    load_data    = (ld_state_q == LD_FIRST) ? ms_if.data_sram_rdata : rdata_hold_q;
    final_result = bus_q.res_from_mem ? load_data : bus_q.result;
    bypass_en    = ms_valid_q && bus_q.gr_we;

    ms_bus.gr_we        = bus_q.gr_we;
    ms_bus.dest         = bus_q.dest;
    ms_bus.final_result = final_result;
    ms_bus.pc           = bus_q.pc;
  end

  assign ms_if.ms_allowin     = ms_allowin;
  assign ms_if.ms_to_ws_valid = ms_valid_q;
  assign ms_if.ms_to_ws_bus   = MS_BUS_W'(ms_bus);
  assign ms_if.ms_to_ds_dest  = bypass_en ? bus_q.dest   : 5'd0;
  assign ms_if.ms_to_ds_value = bypass_en ? final_result : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads with and without stall,
// back-to-back loads, stores, and asynchronous reset in the middle of a stall.
module tb_mem_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_stage_if #(.XLEN(32), .ES_BUS_W(71), .MS_BUS_W(70)) ms_if ();

  mem_stage #(.XLEN(32), .ES_BUS_W(71), .MS_BUS_W(70)) dut (
    .clk   (clk),
    .reset (reset),
    .ms_if (ms_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    ms_if.ws_allowin      = 1'b1;
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.es_to_ms_bus    = '0;
    ms_if.data_sram_rdata = '0;
    #12;

    // Reset state
    chk("rst_valid",   70'(ms_if.ms_to_ws_valid), 70'(1'b0));
    chk("rst_allowin", 70'(ms_if.ms_allowin),     70'(1'b1));
    chk("rst_bus",     ms_if.ms_to_ws_bus,        70'd0);
    chk("rst_dsdest",  70'(ms_if.ms_to_ds_dest),  70'd0);
    chk("rst_dsval",   70'(ms_if.ms_to_ds_value), 70'd0);
    reset = 1'b0;
    #1;

    // 1: ALU op
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'h1c00_0000};
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    #1;
    chk("alu_valid",  70'(ms_if.ms_to_ws_valid), 70'(1'b1));
    chk("alu_bus",    ms_if.ms_to_ws_bus,        {1'b1, 5'd3, 32'h0000_1234, 32'h1c00_0000});
    chk("alu_dsdest", 70'(ms_if.ms_to_ds_dest),  70'd3);
    chk("alu_dsval",  70'(ms_if.ms_to_ds_value), 70'h1234);
    tick();
    chk("alu_gone",   70'(ms_if.ms_to_ws_valid), 70'(1'b0));

    // 2: load, no stall
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b1, 1'b1, 5'd4, 32'h0000_0008, 32'h1c00_0004};
    tick();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_valid",  70'(ms_if.ms_to_ws_valid), 70'(1'b1));
    chk("ld_bus",    ms_if.ms_to_ws_bus,        {1'b1, 5'd4, 32'hDEAD_BEEF, 32'h1c00_0004});
    chk("ld_dsval",  70'(ms_if.ms_to_ds_value), 70'hDEAD_BEEF);
    tick();
    ms_if.data_sram_rdata = '0;
    #1;
    chk("ld_once",   70'(ms_if.ms_to_ws_valid), 70'(1'b0));

    // 3: load under a 3-cycle stall; an ALU op waits upstream and enters as the load leaves
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b1, 1'b1, 5'd5, 32'h0000_0010, 32'h1c00_0008};
    tick();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.ws_allowin      = 1'b0;
    ms_if.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("st_c1_res",   70'(ms_if.ms_to_ws_bus[63:32]), 70'hDEAD_BEEF);
    chk("st_c1_allow", 70'(ms_if.ms_allowin),          70'(1'b0));
    chk("st_c1_valid", 70'(ms_if.ms_to_ws_valid),      70'(1'b1));
    tick();
    ms_if.data_sram_rdata = 32'h1111_1111;
    ms_if.es_to_ms_valid  = 1'b1;
    ms_if.es_to_ms_bus    = {1'b0, 1'b1, 5'd7, 32'h0000_0077, 32'h1c00_000c};
    #1;
    chk("st_c2_bus",   ms_if.ms_to_ws_bus,             {1'b1, 5'd5, 32'hDEAD_BEEF, 32'h1c00_0008});
    chk("st_c2_allow", 70'(ms_if.ms_allowin),          70'(1'b0));
    tick();
    chk("st_c3_res",   70'(ms_if.ms_to_ws_bus[63:32]), 70'hDEAD_BEEF);
    chk("st_c3_dsval", 70'(ms_if.ms_to_ds_value),      70'hDEAD_BEEF);
    tick();
    ms_if.ws_allowin = 1'b1;
    #1;
    chk("st_c4_bus",   ms_if.ms_to_ws_bus,             {1'b1, 5'd5, 32'hDEAD_BEEF, 32'h1c00_0008});
    chk("st_c4_allow", 70'(ms_if.ms_allowin),          70'(1'b1));
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    #1;
    chk("swap_valid",  70'(ms_if.ms_to_ws_valid),      70'(1'b1));
    chk("swap_bus",    ms_if.ms_to_ws_bus,             {1'b1, 5'd7, 32'h0000_0077, 32'h1c00_000c});
    tick();
    chk("swap_gone",   70'(ms_if.ms_to_ws_valid),      70'(1'b0));

    // 4: back-to-back loads
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b1, 1'b1, 5'd9, 32'h0000_0020, 32'h1c00_0010};
    tick();
    ms_if.es_to_ms_bus    = {1'b1, 1'b1, 5'd10, 32'h0000_0024, 32'h1c00_0014};
    ms_if.data_sram_rdata = 32'hA5A5_0001;
    #1;
    chk("b2b_1_bus",   ms_if.ms_to_ws_bus,        {1'b1, 5'd9, 32'hA5A5_0001, 32'h1c00_0010});
    tick();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.data_sram_rdata = 32'hA5A5_0002;
    #1;
    chk("b2b_2_valid", 70'(ms_if.ms_to_ws_valid), 70'(1'b1));
    chk("b2b_2_bus",   ms_if.ms_to_ws_bus,        {1'b1, 5'd10, 32'hA5A5_0002, 32'h1c00_0014});
    tick();
    chk("b2b_gone",    70'(ms_if.ms_to_ws_valid), 70'(1'b0));

    // 5: store (gr_we=0) passes through without bypass
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b0, 1'b0, 5'd6, 32'h0000_0055, 32'h1c00_0018};
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    #1;
    chk("sw_valid",  70'(ms_if.ms_to_ws_valid), 70'(1'b1));
    chk("sw_dsdest", 70'(ms_if.ms_to_ds_dest),  70'd0);
    chk("sw_dsval",  70'(ms_if.ms_to_ds_value), 70'd0);
    chk("sw_bus",    ms_if.ms_to_ws_bus,        {1'b0, 5'd6, 32'h0000_0055, 32'h1c00_0018});
    tick();

    // 6: async reset mid-stall, then a clean load
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b1, 1'b1, 5'd8, 32'h0000_0030, 32'h1c00_001c};
    tick();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.ws_allowin      = 1'b0;
    ms_if.data_sram_rdata = 32'hCAFE_F00D;
    tick();
    chk("pre_rst_valid", 70'(ms_if.ms_to_ws_valid), 70'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid",   70'(ms_if.ms_to_ws_valid), 70'(1'b0));
    chk("mid_rst_allowin", 70'(ms_if.ms_allowin),     70'(1'b1));
    chk("mid_rst_dsdest",  70'(ms_if.ms_to_ds_dest),  70'd0);
    #1;
    reset = 1'b0;
    ms_if.ws_allowin     = 1'b1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {1'b1, 1'b1, 5'd4, 32'h0000_0008, 32'h1c00_0004};
    tick();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("post_rst_bus",  ms_if.ms_to_ws_bus,        {1'b1, 5'd4, 32'hDEAD_BEEF, 32'h1c00_0004});
    chk("post_rst_dsd",  70'(ms_if.ms_to_ds_dest),  70'd4);
    tick();
    chk("post_rst_once", 70'(ms_if.ms_to_ws_valid), 70'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
